// File: rtl/dnn_pkg.sv
// Shared types and constants for the tiny_dnn_core sequencer.
// State encoding, core pipeline latency, fp32 zero.
package dnn_pkg;

  localparam int F_SIZE   = 1024;
  localparam int AW       = 10;
  localparam int FAW      = 16;
  localparam int CORE_LAT = 3;
  localparam int CW       = $clog2(CORE_LAT + 1);

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_EXEC,
    S_BIAS,
    S_DRAIN,
    S_HAND,
    S_FIN
  } state_e;

endpackage

// File: rtl/dnn_seq_out.sv
// Output stage: pending flag, normalize enable, result register.
// Ports: hand_set in, nrm in, res_ready in; pending/norm_en/res_valid/res_data out.
module dnn_seq_out
  import dnn_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hand_set,
  input  logic [31:0] nrm,
  input  logic        res_ready,
  output logic        pending,
  output logic        norm_en,
  output logic        res_valid,
  output logic [31:0] res_data
);

  logic        pend_q, pend_d;
  logic        wait_q, wait_d;
  logic        vld_q, vld_d;
  logic [31:0] data_q, data_d;

  always_comb begin
    pend_d  = pend_q;
    vld_d   = vld_q;
    data_d  = data_q;
    // hand_set only occurs while pend_q is low, so it can
    // fire normalize in the same cycle the bank is handed over
    norm_en = (pend_q | hand_set) & ~vld_q & ~wait_q;
    wait_d  = norm_en;
    if (vld_q & res_ready) vld_d = 1'b0;
    // nrm is valid the cycle after norm_en
    if (wait_q) begin
      data_d = nrm;
      vld_d  = 1'b1;
      pend_d = 1'b0;
    end
    if (hand_set) pend_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= 1'b0;
      wait_q <= 1'b0;
      vld_q  <= 1'b0;
      data_q <= FP32_ZERO;
    end else begin
      pend_q <= pend_d;
      wait_q <= wait_d;
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign pending   = pend_q;
  assign res_valid = vld_q;
  assign res_data  = data_q;

endmodule

// File: rtl/dnn_core_seq.sv
// Sequencer driving one tiny_dnn_core + normalize pair over n_vec vectors.
// Ports: start/fs/n_vec/use_bias/feat_base in; core controls, feat_addr, result port out.
module dnn_core_seq
  import dnn_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [AW-1:0]  fs,
  input  logic [FAW-1:0] n_vec,
  input  logic           use_bias,
  input  logic [FAW-1:0] feat_base,
  output logic           busy,
  output logic           done,
  output logic [FAW-1:0] feat_addr,
  output logic           core_init,
  output logic           core_exec,
  output logic           core_bias,
  output logic [AW-1:0]  core_ra,
  output logic           sum_ip,
  output logic           sum_op,
  output logic           norm_en,
  input  logic [31:0]    nrm,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [31:0]    res_data
);

  state_e         state_q, state_d;
  logic [AW-1:0]  fs_q, fs_d;
  logic [FAW-1:0] nvec_q, nvec_d;
  logic           bias_q, bias_d;
  logic [FAW-1:0] addr_q, addr_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [FAW-1:0] vec_q, vec_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           bank_q, bank_d;
  logic           sop_q, sop_d;
  logic           sip1_q, sip2_q;
  logic           hand_set;
  logic           pending;

  always_comb begin
    state_d   = state_q;
    fs_d      = fs_q;
    nvec_d    = nvec_q;
    bias_d    = bias_q;
    addr_d    = addr_q;
    idx_d     = idx_q;
    vec_d     = vec_q;
    bank_d    = bank_q;
    sop_d     = sop_q;
    cnt_d     = '0;
    hand_set  = 1'b0;
    done      = 1'b0;
    core_init = 1'b0;
    core_exec = 1'b0;
    core_bias = 1'b0;
    core_ra   = '0;
    feat_addr = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          fs_d    = fs;
          nvec_d  = n_vec;
          bias_d  = use_bias;
          addr_d  = feat_base;
          vec_d   = '0;
          bank_d  = 1'b0;
          sop_d   = 1'b0;
          state_d = (n_vec == '0) ? S_FIN : S_INIT;
        end
      end
      S_INIT: begin
        core_init = 1'b1;
        idx_d     = '0;
        if (fs_q != '0)  state_d = S_EXEC;
        else if (bias_q) state_d = S_BIAS;
        else             state_d = S_DRAIN;
      end
      S_EXEC: begin
        core_exec = 1'b1;
        core_ra   = idx_q;
        feat_addr = addr_q;
        // vectors are contiguous, so one running address
        // covers base + v*fs + i with natural wrap
        addr_d    = addr_q + FAW'(1);
        idx_d     = idx_q + AW'(1);
        if (idx_q == fs_q - AW'(1))
          state_d = bias_q ? S_BIAS : S_DRAIN;
      end
      S_BIAS: begin
        core_bias = 1'b1;
        core_ra   = AW'(F_SIZE - 1);
        state_d   = S_DRAIN;
      end
      S_DRAIN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(CORE_LAT - 1)) state_d = S_HAND;
      end
      S_HAND: begin
        // previous bank still awaiting normalize: stall
        if (!pending) begin
          hand_set = 1'b1;
          sop_d    = bank_q;
          bank_d   = ~bank_q;
          vec_d    = vec_q + FAW'(1);
          state_d  = (vec_q == nvec_q - FAW'(1)) ? S_FIN : S_INIT;
        end
      end
      S_FIN: begin
        if (!pending && !res_valid) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      fs_q    <= '0;
      nvec_q  <= '0;
      bias_q  <= 1'b0;
      addr_q  <= '0;
      idx_q   <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
      bank_q  <= 1'b0;
      sop_q   <= 1'b0;
      sip1_q  <= 1'b0;
      sip2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fs_q    <= fs_d;
      nvec_q  <= nvec_d;
      bias_q  <= bias_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      bank_q  <= bank_d;
      sop_q   <= sop_d;
      sip1_q  <= bank_q;
      sip2_q  <= sip1_q;
    end
  end

  // core registers init/exec/bias twice before accumulating
  assign sum_ip = sip2_q;
  assign sum_op = hand_set ? bank_q : sop_q;
  assign busy   = (state_q != S_IDLE) & ~done;

  dnn_seq_out u_out (
    .clk       (clk),
    .rst       (rst),
    .hand_set  (hand_set),
    .nrm       (nrm),
    .res_ready (res_ready),
    .pending   (pending),
    .norm_en   (norm_en),
    .res_valid (res_valid),
    .res_data  (res_data)
  );

endmodule

// File: tb/tb_dnn_core_seq.sv
// Bench for dnn_core_seq with a behavioural core, normalize and feature RAM.
// Results are scored against sums computed directly from weights and features.
module tb_dnn_core_seq;
  import dnn_pkg::*;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [AW-1:0]  fs = '0;
  logic [FAW-1:0] n_vec = '0;
  logic           use_bias = 1'b0;
  logic [FAW-1:0] feat_base = '0;
  logic           res_ready = 1'b0;
  logic           busy, done, core_init, core_exec, core_bias;
  logic           sum_ip, sum_op, norm_en, res_valid;
  logic [FAW-1:0] feat_addr;
  logic [AW-1:0]  core_ra;
  logic [31:0]    nrm = 32'h0;
  logic [31:0]    res_data;

  always #5 clk = ~clk;

  dnn_core_seq dut (
    .clk(clk), .rst(rst), .start(start), .fs(fs), .n_vec(n_vec),
    .use_bias(use_bias), .feat_base(feat_base), .busy(busy), .done(done),
    .feat_addr(feat_addr), .core_init(core_init), .core_exec(core_exec),
    .core_bias(core_bias), .core_ra(core_ra), .sum_ip(sum_ip),
    .sum_op(sum_op), .norm_en(norm_en), .nrm(nrm), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // weights in units of 0.5, features as integers
  int w_h [F_SIZE];
  int mem [1 << FAW];

  function automatic logic [31:0] to_fp32(input int h);
    int p;
    logic [31:0] m;
    if (h <= 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 24; i++) if (h[i]) p = i;
    m = 32'(h) << (23 - p);
    return {1'b0, 8'(p + 126), m[22:0]};
  endfunction

  function automatic int exp_h(input int f, input int b, input int base,
                               input int v);
    int s;
    logic [FAW-1:0] a;
    s = 0;
    for (int i = 0; i < f; i++) begin
      a = FAW'(base + v * f + i);
      s += w_h[i] * mem[a];
    end
    if (b != 0) s += w_h[F_SIZE-1];
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // core/normalize/RAM environment model
  int ram_q = 0;
  int c1_op = 0, c2_op = 0, c1_ra = 0, c2_ra = 0, c2_d = 0;
  int acc [2];
  logic init_d1 = 1'b0, init_d2 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      c1_op   <= 0;
      c2_op   <= 0;
      init_d1 <= 1'b0;
      init_d2 <= 1'b0;
      nrm     <= 32'h0;
    end else begin
      ram_q   <= mem[feat_addr];
      c1_op   <= core_init ? 1 : core_exec ? 2 : core_bias ? 3 : 0;
      c1_ra   <= int'(core_ra);
      c2_op   <= c1_op;
      c2_ra   <= c1_ra;
      c2_d    <= ram_q;
      init_d1 <= core_init;
      init_d2 <= init_d1;
      case (c2_op)
        1: acc[sum_ip] <= 0;
        2: acc[sum_ip] <= acc[sum_ip] + w_h[c2_ra] * c2_d;
        3: acc[sum_ip] <= acc[sum_ip] + w_h[F_SIZE-1];
        default: ;
      endcase
      if (norm_en) nrm <= to_fp32(acc[sum_op]);
    end
  end

  // scoreboard / compare process
  logic [31:0] exp_q [$];
  logic [31:0] res_log [$];
  logic        sip_q [$];
  int          n_res = 0, n_done = 0;
  int          acc_cyc = 0, done_cyc = 0, rv_cyc = 0, bias_cyc = 0;
  logic [31:0] last_res = 32'h0;
  logic        hold_prev = 1'b0, prev_valid = 1'b0;
  logic [31:0] hold_data = 32'h0;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_result: got %h want none", res_data);
        end else begin
          chk("result", res_data, exp_q.pop_front());
        end
        last_res = res_data;
        res_log.push_back(res_data);
        acc_cyc = cyc;
        n_res++;
      end
      if (hold_prev) begin
        chk("hold_valid", 32'(res_valid), 32'd1);
        chk("hold_data", res_data, hold_data);
      end
      hold_prev = res_valid && !res_ready;
      hold_data = res_data;
      if (res_valid && !prev_valid) rv_cyc = cyc;
      prev_valid = res_valid;
      if (core_bias) bias_cyc = cyc;
      if (done) begin
        done_cyc = cyc;
        n_done++;
      end
      if (init_d2) sip_q.push_back(sum_ip);
    end
  end

  int start_cyc = 0;

  task automatic pulse_start(input int f, input int nv, input int b,
                             input int base);
    @(posedge clk);
    #1;
    fs        = AW'(f);
    n_vec     = FAW'(nv);
    use_bias  = b[0];
    feat_base = FAW'(base);
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic push_exp(input int f, input int nv, input int b,
                          input int base);
    for (int v = 0; v < nv; v++)
      exp_q.push_back(to_fp32(exp_h(f, b, base, v)));
  endtask

  task automatic wait_done(input string nm, input int lim);
    logic got;
    got = 1'b0;
    for (int k = 0; k < lim && !got; k++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk(nm, 32'(got), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input string nm, input int f, input int nv,
                         input int b, input int base);
    push_exp(f, nv, b, base);
    pulse_start(f, nv, b, base);
    wait_done({nm, "_done"}, 400);
    chk({nm, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, 32'({busy, done, core_init, core_exec, core_bias,
                           sum_ip, sum_op, norm_en, res_valid}), 32'd0);
    chk({nm, "_addr"}, 32'({feat_addr, core_ra}), 32'd0);
    chk({nm, "_data"}, res_data, 32'd0);
  endtask

  int r0, d0;

  initial begin
    for (int i = 0; i < F_SIZE; i++) w_h[i] = 0;
    for (int i = 0; i < (1 << FAW); i++) mem[i] = 0;
    acc[0] = 0;
    acc[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    res_ready = 1'b1;

    // 1.0*1.0 + 1.0*2.0 + 0.5 = 3.5
    w_h[0] = 2; w_h[1] = 2; w_h[F_SIZE-1] = 1;
    mem[100] = 1; mem[101] = 2;
    run_job("a", 2, 1, 1, 100);
    chk("a_value", last_res, 32'h4060_0000);
    chk("a_latency", 32'(rv_cyc - bias_cyc), 32'd6);
    chk("a_done_after_accept", 32'(done_cyc - acc_cyc), 32'd1);
    chk("a_busy_low", 32'(busy), 32'd0);

    // three vectors, feature addresses wrap past 0xFFFF
    w_h[0] = 2; w_h[1] = 4; w_h[2] = 1; w_h[3] = 3;
    for (int k = 0; k < 12; k++) mem[(16'hFFF8 + k) & 16'hFFFF] = k + 1;
    sip_q.delete();
    res_log.delete();
    r0 = n_res;
    run_job("b", 4, 3, 1, 16'hFFF8);
    chk("b_count", 32'(n_res - r0), 32'd3);
    chk("b_sip_n", 32'(sip_q.size()), 32'd3);
    if (sip_q.size() == 3) begin
      chk("b_sip0", 32'(sip_q[0]), 32'd0);
      chk("b_sip1", 32'(sip_q[1]), 32'd1);
      chk("b_sip2", 32'(sip_q[2]), 32'd0);
    end
    // 1*1 + 2*2 + 0.5*3 + 1.5*4 + 0.5 = 13.0
    if (res_log.size() > 0) chk("b_first", res_log[0], 32'h4150_0000);

    // downstream back-pressure
    r0 = n_res;
    push_exp(4, 3, 1, 16'hFFF8);
    res_ready = 1'b0;
    pulse_start(4, 3, 1, 16'hFFF8);
    repeat (25) @(posedge clk);
    #1;
    chk("c_stall_busy", 32'(busy), 32'd1);
    chk("c_stall_valid", 32'(res_valid), 32'd1);
    chk("c_stall_data", res_data, 32'h4150_0000);
    chk("c_stall_count", 32'(n_res - r0), 32'd0);
    res_ready = 1'b1;
    wait_done("c_done", 400);
    chk("c_count", 32'(n_res - r0), 32'd3);
    chk("c_drained", 32'(exp_q.size()), 32'd0);

    // bias only, and empty vector
    w_h[F_SIZE-1] = 4;
    run_job("d1", 0, 1, 1, 0);
    chk("d1_value", last_res, 32'h4000_0000);
    r0 = n_res;
    run_job("d2", 0, 1, 0, 0);
    chk("d2_value", last_res, 32'h0000_0000);
    chk("d2_count", 32'(n_res - r0), 32'd1);

    // abort mid-EXEC
    w_h[1] = 2;
    w_h[F_SIZE-1] = 1;
    pulse_start(8, 2, 1, 0);
    begin
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        if (core_exec) seen = 1'b1;
      end
      chk("e_exec_seen", 32'(seen), 32'd1);
    end
    #2;
    rst = 1'b1;
    #1;
    chk_zero("e_abort");
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    hold_prev = 1'b0;
    run_job("e", 2, 1, 1, 100);
    chk("e_value", last_res, 32'h4060_0000);

    // start while busy is ignored
    r0 = n_res;
    d0 = n_done;
    push_exp(2, 1, 1, 100);
    pulse_start(2, 1, 1, 100);
    pulse_start(4, 3, 0, 0);
    wait_done("f_done", 400);
    repeat (30) @(posedge clk);
    #1;
    chk("f_count", 32'(n_res - r0), 32'd1);
    chk("f_value", last_res, 32'h4060_0000);
    chk("f_done_once", 32'(n_done - d0), 32'd1);
    chk("f_idle", 32'(busy), 32'd0);

    // zero vectors
    r0 = n_res;
    pulse_start(2, 0, 1, 100);
    wait_done("g_done", 10);
    chk("g_done_cycle", 32'(done_cyc - start_cyc), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("g_no_result", 32'(n_res - r0), 32'd0);
    chk("g_valid", 32'(res_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
